// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver: off / steady / blink / breathe with PWM brightness.
// Define LED_PATTERN_STAGGER_EN to invert blink phase and breathe level on odd channels.
module led_pattern_gen #(
   parameter int CHANNELS = 4,
   parameter int CLK_HZ   = 50000000,
   parameter int TICK_HZ  = 1000,
   parameter int PWM_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [15:0]           period,
   input  logic [PWM_BITS-1:0]   duty,
   output logic                  tick,
   output logic [CHANNELS-1:0]   led
);

   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int PS_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   logic [PS_W-1:0]     ps_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [15:0]         blink_cnt;
   logic                blink_phase;
   logic [PWM_BITS-1:0] level;
   dir_e                dir;
   logic [15:0]         period_m1;
   logic [PWM_BITS-1:0] target [CHANNELS];

   // A period of 0 behaves like 1, so the phase toggles on every tick.
   assign period_m1 = (period == 16'd0) ? 16'd0 : period - 16'd1;

   // tick is registered one count early so it is high exactly while ps_cnt sits at DIV-1.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_cnt      <= '0;
         tick        <= 1'b0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         level       <= '0;
         dir         <= DIR_UP;
      end else begin
         tick    <= (ps_cnt == PS_W'(DIV - 2));
         ps_cnt  <= (ps_cnt == PS_W'(DIV - 1)) ? '0 : ps_cnt + 1'b1;
         pwm_cnt <= pwm_cnt + 1'b1;
         if (tick) begin
            // >= rather than == so a shrunk period never waits for a 16-bit wrap.
            if (blink_cnt >= period_m1) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 16'd1;
            end
            case (dir)
               DIR_UP: begin
                  level <= level + 1'b1;
                  if (level == LVL_MAX - 1'b1) dir <= DIR_DOWN;
               end
               default: begin
                  level <= level - 1'b1;
                  if (level == PWM_BITS'(1)) dir <= DIR_UP;
               end
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         logic                ph;
         logic [PWM_BITS-1:0] lv;
         // NOTE: every path assigns a value first, so no latch is inferred.
         ph = blink_phase;
         lv = level;
`ifdef LED_PATTERN_STAGGER_EN
         if (i % 2 == 1) begin
            ph = ~blink_phase;
            lv = ~level;
         end
`endif
         case (mode_e'(mode[2*i +: 2]))
            MODE_OFF:     target[i] = '0;
            MODE_ON:      target[i] = duty;
            MODE_BLINK:   target[i] = ph ? duty : '0;
            default:      target[i] = lv;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            led[i] <= (pwm_cnt < target[i]);
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (10-cycle tick, 4-bit PWM, 4 channels).
// Expected LED values come from a closed-form model of pwm/tick/ramp plus a per-tick blink model.
module tb_led_pattern_gen;

   localparam int CH   = 4;
   localparam int PB   = 4;
   localparam int DIV  = 10;
   localparam int LMAX = (1 << PB) - 1;

   logic          clk;
   logic          rst_n;
   logic [2*CH-1:0] mode;
   logic [15:0]   period;
   logic [PB-1:0] duty;
   logic          tick;
   logic [CH-1:0] led;

   int compared;
   int mismatched;

   led_pattern_gen #(
      .CHANNELS(CH), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(PB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .period(period),
      .duty(duty), .tick(tick), .led(led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: m_n = clock edges since reset release.
   int          m_n;
   int          m_bcnt;
   bit          m_phase;
   logic [CH-1:0] exp_led;
   logic        exp_tick;

   // Breathe level after t ticks: triangle 0..LMAX..0 with period 2*LMAX.
   function automatic int tri_level(input int t);
      int r;
      r = t % (2 * LMAX);
      return (r <= LMAX) ? r : 2 * LMAX - r;
   endfunction

   function automatic int target_of(input logic [1:0] md, input int dt, input bit ph,
                                    input int lv, input int ch);
      bit p;
      int l;
      p = ph;
      l = lv;
`ifdef LED_PATTERN_STAGGER_EN
      if (ch % 2 == 1) begin
         p = !ph;
         l = LMAX - lv;
      end
`endif
      case (md)
         2'b00:   return 0;
         2'b01:   return dt;
         2'b10:   return p ? dt : 0;
         default: return l;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n      = 0;
         m_bcnt   = 0;
         m_phase  = 0;
         exp_led  = '0;
         exp_tick = 1'b0;
      end else begin
         int pmax;
         for (int i = 0; i < CH; i++) begin
            exp_led[i] = ((m_n % (LMAX + 1)) <
                          target_of(mode[2*i +: 2], int'(duty), m_phase, tri_level(m_n / DIV), i));
         end
         if (m_n % DIV == DIV - 1) begin
            pmax = (period == 16'd0) ? 1 : int'(period);
            if (m_bcnt >= pmax - 1) begin
               m_bcnt  = 0;
               m_phase = !m_phase;
            end else begin
               m_bcnt = m_bcnt + 1;
            end
         end
         m_n      = m_n + 1;
         exp_tick = (m_n % DIV == DIV - 1);
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int first_tick;
      mode   = 8'b01010101;
      duty   = 4'd8;
      period = 16'd3;
      repeat (37) begin
         @(negedge clk);
         compared++;
         if (led !== exp_led || tick !== exp_tick) begin
            mismatched++;
            $display("FAIL reset_prerun: led=%b tick=%b expected led=%b tick=%b", led, tick, exp_led, exp_tick);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if (led !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_led_async: led=%b expected 0000", led);
      end
      compared++;
      if (tick !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_tick_async: tick=%b expected 0", tick);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first_tick = -1;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (tick === 1'b1 && first_tick < 0) first_tick = c;
         compared++;
         if (led !== exp_led || tick !== exp_tick) begin
            mismatched++;
            $display("FAIL reset_release: edge %0d led=%b tick=%b expected led=%b tick=%b", c, led, tick, exp_led, exp_tick);
         end
      end
      compared++;
      if (first_tick != 9) begin
         mismatched++;
         $display("FAIL first_tick: seen after edge %0d expected after edge 9 (cycle 10)", first_tick);
      end
   endtask

   task automatic test_on_duty();
      logic [PB-1:0] duties [4];
      int highs;
      duties[0] = 4'd5;
      duties[1] = 4'd0;
      duties[2] = 4'd15;
      duties[3] = PB'($urandom_range(1, 14));
      mode = 8'b01010101;
      for (int d = 0; d < 4; d++) begin
         @(negedge clk);
         duty = duties[d];
         @(negedge clk);
         highs = 0;
         repeat (16) begin
            @(negedge clk);
            highs += int'(led[0]);
            compared++;
            if (led !== exp_led) begin
               mismatched++;
               $display("FAIL on_duty_cycle: duty=%0d led=%b expected %b", duty, led, exp_led);
            end
         end
         compared++;
         if (highs != int'(duties[d])) begin
            mismatched++;
            $display("FAIL on_duty_count: duty=%0d high %0d of 16 expected %0d", duties[d], highs, duties[d]);
         end
      end
   endtask

   task automatic test_blink();
      apply_reset();
      mode   = 8'b00000010;
      duty   = 4'd15;
      period = 16'd3;
      repeat (130) begin
         @(negedge clk);
         compared++;
         if (led !== exp_led || tick !== exp_tick) begin
            mismatched++;
            $display("FAIL blink_p3: led=%b tick=%b expected led=%b tick=%b", led, tick, exp_led, exp_tick);
         end
      end
      period = 16'd0;
      repeat (60) begin
         @(negedge clk);
         compared++;
         if (led !== exp_led) begin
            mismatched++;
            $display("FAIL blink_p0: led=%b expected %b", led, exp_led);
         end
      end
   endtask

   task automatic test_breathe();
      apply_reset();
      mode = 8'b00001100;
      duty = 4'd3;
      repeat (320) begin
         @(negedge clk);
         compared++;
         if (led !== exp_led) begin
            mismatched++;
            $display("FAIL breathe_ramp: led=%b expected %b", led, exp_led);
         end
      end
      repeat ($urandom_range(60, 140)) @(negedge clk);
      apply_reset();
      repeat (200) begin
         @(negedge clk);
         compared++;
         if (led !== exp_led) begin
            mismatched++;
            $display("FAIL breathe_after_reset: led=%b expected %b", led, exp_led);
         end
      end
   endtask

   task automatic test_period_shrink();
      apply_reset();
      mode   = 8'b10101010;
      duty   = 4'd15;
      period = 16'd100;
      repeat (500) @(negedge clk);
      period = 16'd4;
      repeat (140) begin
         @(negedge clk);
         compared++;
         if (led !== exp_led) begin
            mismatched++;
            $display("FAIL period_shrink: led=%b expected %b", led, exp_led);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 15; r++) begin
         @(negedge clk);
         mode   = 8'($urandom);
         duty   = PB'($urandom);
         period = 16'($urandom_range(0, 5));
         repeat (20) begin
            @(negedge clk);
            compared++;
            if (led !== exp_led || tick !== exp_tick) begin
               mismatched++;
               $display("FAIL random: mode=%b duty=%0d period=%0d led=%b tick=%b expected led=%b tick=%b",
                        mode, duty, period, led, tick, exp_led, exp_tick);
            end
         end
      end
   endtask

   task automatic test_stagger();
      apply_reset();
      mode   = 8'b10101010;
      duty   = 4'd15;
      period = 16'd2;
      repeat (80) begin
         @(negedge clk);
         compared++;
         if (led[0] !== led[2] || led[1] !== led[3]) begin
            mismatched++;
            $display("FAIL stagger_pairs: led=%b expected led0==led2 and led1==led3", led);
         end
`ifdef LED_PATTERN_STAGGER_EN
         compared++;
         if (led[0] === 1'b1 && led[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL stagger_opposed: led=%b expected odd channels off while even active", led);
         end
`else
         compared++;
         if (led[0] !== led[1]) begin
            mismatched++;
            $display("FAIL stagger_locked: led=%b expected all channels equal", led);
         end
`endif
         compared++;
         if (led !== exp_led) begin
            mismatched++;
            $display("FAIL stagger_model: led=%b expected %b", led, exp_led);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n  = 1'b0;
      mode   = '0;
      period = 16'd1;
      duty   = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_on_duty();
      test_blink();
      test_breathe();
      test_period_shrink();
      test_random();
      test_stagger();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED driver that replaces the single fixed-rate divider blinker on the board's user LEDs. Each channel independently shows off, steady, blink or breathe, with PWM brightness control, from a shared prescaled timebase derived from the 50 MHz board clock. The block sits between control/status logic (mode, period and duty inputs) and the LED pins.

## Interface
Parameters:
- CHANNELS, 4: number of LED outputs (1..8)
- CLK_HZ, 50000000: input clock frequency
- TICK_HZ, 1000: timebase tick rate; the prescaler divides by CLK_HZ/TICK_HZ (integer, ≥2)
- PWM_BITS, 8: PWM resolution and brightness width

Ports:
- clk  in  1  board clock, 50 MHz; single clock domain
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk upstream
- mode  in  2*CHANNELS  per-channel mode; bits [2i+1:2i] select channel i: 00 off, 01 on, 10 blink, 11 breathe
- period  in  16  blink half-period in ticks; shared by all channels
- duty  in  PWM_BITS  brightness for on and blink modes; shared
- tick  out  1  one-cycle pulse per timebase tick (status/debug)
- led  out  CHANNELS  registered LED drive, active-high

## Operation
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1, then wraps; tick=1 for exactly the cycle in which the count equals its terminal value.
- PWM counter: free-running PWM_BITS-bit counter, increments every clk and wraps from all-ones to 0.
- Blink phase: 16-bit tick counter. On each tick, if count ≥ period-1 then count←0 and phase toggles, else count increments. period=0 is treated as 1, so phase toggles every tick.
- Breathe ramp: PWM_BITS-bit level plus direction bit (up after reset). On each tick going up: level+1; at all-ones, the direction flips to down in the same update. Going down: level-1; at 0, the direction flips to up. The triangle period is 2*(2^PWM_BITS-1) ticks. The ramp never saturates or wraps.
- Per-channel target level: off→0; on→duty; blink→duty when phase=1, else 0; breathe→ramp level.
- Output: led[i] ← (pwm_cnt < target_i), registered. target=0 gives constant 0. target=all-ones gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- mode, period and duty are sampled every cycle. A change affects led on the next clk edge; no counter is reset.
- Timebase, blink and ramp are shared, so channels in the same mode are phase-locked, except as described under Configuration.

## Timing
- Reset (rst_n=0, asynchronous): prescaler=0, pwm_cnt=0, blink count=0, phase=0, level=0, direction=up; tick=0, led=all 0. This takes effect immediately, including mid-ramp or mid-blink.
- First tick: CLK_HZ/TICK_HZ cycles after the first rising clk edge with rst_n=1.
- Latency: mode/duty/pwm_cnt to led is 1 cycle. A tick's phase or level update becomes visible on led 1 cycle after the tick cycle.
- When a period change arrives while count > new period-1, the next tick toggles the phase and clears the count. There is no long wrap-around.
- When tick and pwm_cnt wrap coincide, no special handling applies; each counter updates independently.

## Configuration
- LED_PATTERN_STAGGER_EN defined: odd-numbered channels use the inverted blink phase, and in breathe they use level' = ~level. Adjacent channels therefore alternate and cross-fade.
- Not defined: all channels share the same phase and level; odd and even channels behave identically.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), PWM_BITS=4, CHANNELS=4.
- Reset: hold rst_n=0 mid-run with mode=all on, duty=8 -> led=0000 and tick=0 immediately. After release, the first tick occurs on cycle 10.
- On/duty: mode=01 on all channels, duty=5 -> each led is high 5 of every 16 cycles. duty=0 -> always 0. duty=15 -> high 15 of 16.
- Blink: mode ch0=10, duty=15, period=3 -> ch0 PWM-active for 3 ticks (30 cycles), then off for 30 cycles, repeating. period=0 -> toggles every tick.
- Breathe: mode ch1=11 -> level goes 0→15 over 15 ticks, then 15→0 over 15 ticks (300-cycle triangle). Per-16-cycle high count equals level. Reset mid-ramp returns level to 0 with direction up.
- Period shrink: period=100 with count at 50, then set period=4 -> phase toggles on the next tick and then every 4 ticks.
- Stagger: with LED_PATTERN_STAGGER_EN and mode=all blink -> led[1] and led[3] are off when led[0] and led[2] are PWM-active. Without the macro, all four match.
